// File: rtl/main_memory_slave_if.sv
// Request/response bus between a cache-side master and main_memory_slave.
interface main_memory_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              req_read;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              snoop_flush;
  logic [DATA_W-1:0] flush_data;
  logic [DATA_W-1:0] data_out;
  logic              ack;
  logic              busy;
  logic              parity_err;

  modport master (
    output req_read, req_write, req_addr, req_wdata, snoop_flush, flush_data,
    input  data_out, ack, busy, parity_err
  );

  modport slave (
    input  req_read, req_write, req_addr, req_wdata, snoop_flush, flush_data,
    output data_out, ack, busy, parity_err
  );
endinterface

// File: rtl/main_memory_slave.sv
// Fixed-latency main memory slave that forwards snoop-flushed lines to pending reads.
// Defining MEM_PARITY_EN adds a per-word even-parity bit and drives parity_err on reads.
module main_memory_slave #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input logic                clock,
  input logic                reset,
  main_memory_slave_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  is_write_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  flush_hit_q;
  logic [DATA_W-1:0]     flush_q;
  logic                  ack_q;
  logic [DATA_W-1:0]     data_q;
  logic                  accept;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_wdata;

  // No reset on the array so it maps onto block RAM, which configures to zero.
  logic [DATA_W-1:0] mem [DEPTH];

  assign accept    = (state_q == IDLE) && (bus.req_read || bus.req_write);
  assign mem_we    = (state_q == RESP) && (is_write_q || flush_hit_q);
  assign mem_wdata = is_write_q ? wdata_q : flush_q;

  assign bus.ack      = ack_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.data_out = data_q;

  generate
    if (DEPTH_LOG2 < ADDR_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:DEPTH_LOG2];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, latency counter, snoop capture and the registered response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      is_write_q  <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      flush_hit_q <= 1'b0;
      flush_q     <= '0;
      ack_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      ack_q <= (state_q == RESP);
      case (state_q)
        IDLE: begin
          if (accept) begin
            is_write_q  <= bus.req_write;
            idx_q       <= bus.req_addr[DEPTH_LOG2-1:0];
            wdata_q     <= bus.req_wdata;
            cnt_q       <= CNT_LOAD;
            flush_hit_q <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          if (!is_write_q && bus.snoop_flush) begin
            flush_hit_q <= 1'b1;
            flush_q     <= bus.flush_data;
          end
        end
        RESP: begin
          if (!is_write_q) data_q <= flush_hit_q ? flush_q : mem[idx_q];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[idx_q] <= mem_wdata;
  end

`ifdef MEM_PARITY_EN
  logic par_mem [DEPTH];
  logic perr_q;

  always_ff @(posedge clock) begin
    if (mem_we) par_mem[idx_q] <= ^mem_wdata;
  end

  // Flush-served reads never touch the stored word, so they cannot report a fault.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perr_q <= 1'b0;
    end else if (state_q == RESP) begin
      perr_q <= !is_write_q && !flush_hit_q && ((^mem[idx_q]) != par_mem[idx_q]);
    end
  end

  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_main_memory_slave.sv
// Scoreboard bench for main_memory_slave: directed scenarios, then randomized traffic
// checked against an array model; a second instance covers LATENCY=1.
module tb_main_memory_slave;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 16;
  localparam int DEPTH_LOG2 = 10;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int LAT0       = 4;
  localparam int LAT1       = 1;

  typedef struct {
    bit                is_read;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t sb0[$];
  exp_t sb1[$];
  logic [DATA_W-1:0] model0 [DEPTH];
  logic [DATA_W-1:0] model1 [DEPTH];
  logic [DATA_W-1:0] last_read0 = '0;
  logic [DATA_W-1:0] last_read1 = '0;

  main_memory_slave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus0 ();
  main_memory_slave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();

  main_memory_slave #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LAT0)
  ) dut0 (
    .clock(clock), .reset(reset), .bus(bus0)
  );

  main_memory_slave #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LAT1)
  ) dut1 (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every ack must match the oldest outstanding expectation in time and data.
  always @(negedge clock) begin : mon0
    exp_t e;
    if (!reset) begin
      last_read0 = '0;
    end else if (bus0.ack) begin
      if (sb0.size() == 0) begin
        checkOutput("dut0 unexpected ack", 64'(bus0.ack), 64'(0));
      end else begin
        e = sb0.pop_front();
        checkOutput("dut0 ack cycle", 64'(cyc), 64'(e.cyc));
        checkOutput("dut0 busy at ack", 64'(bus0.busy), 64'(0));
        checkOutput("dut0 parity_err", 64'(bus0.parity_err), 64'(0));
        if (e.is_read) begin
          checkOutput("dut0 read data", 64'(bus0.data_out), 64'(e.data));
          last_read0 = e.data;
        end else begin
          checkOutput("dut0 data_out held on write", 64'(bus0.data_out), 64'(last_read0));
        end
      end
    end
  end

  always @(negedge clock) begin : mon1
    exp_t e;
    if (!reset) begin
      last_read1 = '0;
    end else if (bus1.ack) begin
      if (sb1.size() == 0) begin
        checkOutput("dut1 unexpected ack", 64'(bus1.ack), 64'(0));
      end else begin
        e = sb1.pop_front();
        checkOutput("dut1 ack cycle", 64'(cyc), 64'(e.cyc));
        if (e.is_read) begin
          checkOutput("dut1 read data", 64'(bus1.data_out), 64'(e.data));
          last_read1 = e.data;
        end else begin
          checkOutput("dut1 data_out held on write", 64'(bus1.data_out), 64'(last_read1));
        end
      end
    end
  end

  task automatic wait_idle0();
    int n = 0;
    while (bus0.busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (bus0.busy) checkOutput("dut0 idle timeout", 64'(bus0.busy), 64'(0));
  endtask

  // One transaction on dut0; flush_mask bit k pulses snoop_flush in the k-th cycle after accept.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata, input int flush_mask,
                               input logic [DATA_W-1:0] fixed_fdata, input bit hold_req,
                               input bit junk);
    logic [DATA_W-1:0]     fdata [LAT0+2];
    logic [DEPTH_LOG2-1:0] idx;
    exp_t                  e;
    for (int k = 0; k <= LAT0 + 1; k++) fdata[k] = (fixed_fdata != '0) ? fixed_fdata : $urandom;
    idx = DEPTH_LOG2'(int'(addr) % DEPTH);
    wait_idle0();
    bus0.req_read    = rd;
    bus0.req_write   = wr;
    bus0.req_addr    = addr;
    bus0.req_wdata   = wdata;
    bus0.snoop_flush = junk;
    bus0.flush_data  = fdata[0];
    @(negedge clock);
    e.cyc     = cyc + LAT0 + 1;
    e.is_read = !wr;
    if (wr) begin
      model0[idx] = wdata;
      e.data      = wdata;
    end else begin
      e.data = model0[idx];
      for (int k = 1; k <= LAT0; k++) if (flush_mask[k]) e.data = fdata[k];
      model0[idx] = e.data;
    end
    sb0.push_back(e);
    checkOutput("dut0 busy after accept", 64'(bus0.busy), 64'(1));
    for (int k = 1; k <= LAT0 + 1; k++) begin
      bus0.snoop_flush = flush_mask[k];
      bus0.flush_data  = fdata[k];
      if (!hold_req) begin
        bus0.req_read  = 1'b0;
        bus0.req_write = 1'b0;
      end
      bus0.req_addr  = ADDR_W'($urandom);
      bus0.req_wdata = $urandom;
      @(negedge clock);
    end
    bus0.snoop_flush = 1'b0;
    bus0.req_read    = 1'b0;
    bus0.req_write   = 1'b0;
  endtask

  task automatic apply_held_read(input logic [ADDR_W-1:0] addr, input int n);
    exp_t                  e;
    int                    t0;
    logic [DEPTH_LOG2-1:0] idx;
    idx = DEPTH_LOG2'(int'(addr) % DEPTH);
    wait_idle0();
    bus0.req_read    = 1'b1;
    bus0.req_write   = 1'b0;
    bus0.req_addr    = addr;
    bus0.snoop_flush = 1'b0;
    @(negedge clock);
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      e.is_read = 1'b1;
      e.data    = model0[idx];
      e.cyc     = t0 + i * (LAT0 + 2) + LAT0 + 1;
      sb0.push_back(e);
    end
    while (cyc < t0 + (n - 1) * (LAT0 + 2) + LAT0 + 1) begin
      if (cyc >= t0 + (n - 1) * (LAT0 + 2)) bus0.req_read = 1'b0;
      @(negedge clock);
    end
    bus0.req_read = 1'b0;
  endtask

  // Reset lands in WAIT of a write: nothing is expected back and memory must keep its old word.
  task automatic apply_reset_abort(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    wait_idle0();
    bus0.req_read  = 1'b0;
    bus0.req_write = 1'b1;
    bus0.req_addr  = addr;
    bus0.req_wdata = wdata;
    @(negedge clock);
    bus0.req_write = 1'b0;
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort ack", 64'(bus0.ack), 64'(0));
    checkOutput("abort busy", 64'(bus0.busy), 64'(0));
    checkOutput("abort data_out", 64'(bus0.data_out), 64'(0));
    checkOutput("abort parity_err", 64'(bus0.parity_err), 64'(0));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic apply_stimulus1(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata);
    exp_t                  e;
    logic [DEPTH_LOG2-1:0] idx;
    int                    n = 0;
    idx = DEPTH_LOG2'(int'(addr) % DEPTH);
    while (bus1.busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (bus1.busy) checkOutput("dut1 idle timeout", 64'(bus1.busy), 64'(0));
    bus1.req_read  = rd;
    bus1.req_write = wr;
    bus1.req_addr  = addr;
    bus1.req_wdata = wdata;
    @(negedge clock);
    e.cyc     = cyc + LAT1 + 1;
    e.is_read = !wr;
    if (wr) begin
      model1[idx] = wdata;
      e.data      = wdata;
    end else begin
      e.data = model1[idx];
    end
    sb1.push_back(e);
    bus1.req_read  = 1'b0;
    bus1.req_write = 1'b0;
    repeat (LAT1 + 1) @(negedge clock);
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    int                op;
    int                mask;
    int                n;
    for (int i = 0; i < DEPTH; i++) begin
      model0[i] = '0;
      model1[i] = '0;
    end
    bus0.req_read = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus0.snoop_flush = 1'b0; bus0.flush_data = '0;
    bus1.req_read = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    bus1.snoop_flush = 1'b0; bus1.flush_data = '0;

    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("reset ack", 64'(bus0.ack), 64'(0));
    checkOutput("reset busy", 64'(bus0.busy), 64'(0));
    checkOutput("reset data_out", 64'(bus0.data_out), 64'(0));
    checkOutput("reset parity_err", 64'(bus0.parity_err), 64'(0));
    checkOutput("dut1 reset busy", 64'(bus1.busy), 64'(0));
    reset = 1'b1;

    applyStimulus(1'b0, 1'b1, 16'h0002, 32'hABCDEF12, 0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0002, '0, 0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0002, '0, 1 << 2, 32'h12345678, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0002, '0, 0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0402, 32'h00000055, 0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0002, '0, 0, '0, 1'b0, 1'b0);
    apply_held_read(16'h0002, 3);
    applyStimulus(1'b1, 1'b0, 16'h0007, '0, (1 << 1) | (1 << 3), '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0008, 32'h0000CAFE, 32'h3E, '0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0008, '0, 1 << (LAT0 + 1), '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0003, 32'h00000011, 0, '0, 1'b0, 1'b0);
    apply_reset_abort(16'h0003, 32'h00000077);
    applyStimulus(1'b1, 1'b0, 16'h0003, '0, 0, '0, 1'b0, 1'b0);

    apply_stimulus1(1'b1, 1'b1, 16'h0005, 32'h00000009);
    apply_stimulus1(1'b1, 1'b0, 16'h0005, '0);
    apply_stimulus1(1'b1, 1'b0, 16'h0405, '0);

    for (int t = 0; t < 150; t++) begin
      a    = ADDR_W'(($urandom_range(0, 63) << DEPTH_LOG2) | $urandom_range(0, 15));
      op   = $urandom_range(0, 2);
      mask = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 63)) : 0;
      applyStimulus(op != 1, op != 0, a, $urandom, mask, '0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput("scoreboard drained", 64'(sb0.size() + sb1.size()), 64'(0));
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
